// File: rtl/gtxe2_chnl_cpll_seq_if.sv
// Control/status bundle between a CPLL power-up sequencer and its user.
// The master side drives start and forwards the raw PLL status lines. The
// slave side is the sequencer, which returns the PLL control pins and status.
interface gtxe2_chnl_cpll_seq_if;
    logic       start;
    logic       cplllock;
    logic       cpllrefclklost;
    logic       cpllpd;
    logic       cpllreset;
    logic       cplllocken;
    logic       done;
    logic       fail;
    logic [3:0] retries;

    modport master (
        output start, cplllock, cpllrefclklost,
        input  cpllpd, cpllreset, cplllocken, done, fail, retries
    );

    modport slave (
        input  start, cplllock, cpllrefclklost,
        output cpllpd, cpllreset, cplllocken, done, fail, retries
    );
endinterface

// File: rtl/gtxe2_chnl_cpll_seq.sv
// GTXE2 channel PLL (CPLL) power-up and lock sequencer.
//
// Sequence: hold CPLLPD, then pulse CPLLRESET, then wait for CPLLLOCK.
// A timeout or a lost reference clock while waiting triggers a retry, up to
// MAX_RETRIES times; after that the block parks in FAIL until start or reset.
// One shared 20-bit down-counter times every state. A state entered with a
// load value N lasts exactly N cycles.
//
// Optional feature macro: GTXE2_CHNL_CPLL_SEQ_AUTORESTART_EN
//   defined   : losing lock while LOCKED restarts from RST with retries cleared
//   undefined : losing lock while LOCKED parks the block in FAIL
module gtxe2_chnl_cpll_seq #(
    parameter int unsigned PD_CYCLES    = 16,
    parameter int unsigned RESET_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    gtxe2_chnl_cpll_seq_if.slave        bus
);

    localparam logic [19:0] PD_LOAD   = 20'(PD_CYCLES);
    localparam logic [19:0] RST_LOAD  = 20'(RESET_CYCLES);
    localparam logic [19:0] LOCK_LOAD = 20'(LOCK_TIMEOUT);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PD,
        S_RST,
        S_WAIT,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  retries_q, retries_d;

    // Two-flop synchronizers for the asynchronous PLL status inputs.
    logic        lk_meta_q, lk_meta_d;
    logic        lk_s_q, lk_s_d;
    logic        rl_meta_q, rl_meta_d;
    logic        rl_s_q, rl_s_d;

    // Registered outputs, computed from the next state.
    logic        cpllpd_q, cpllpd_d;
    logic        cpllreset_q, cpllreset_d;
    logic        cplllocken_q, cplllocken_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;

    // Counter value that marks the final cycle of a timed state.
    logic        cnt_last;
    // Lock is considered lost when the PLL drops lock or the refclk goes away.
    logic        lock_lost;

    // Saturating retry increment: never exceeds MAX_RETRIES, never wraps.
    function automatic logic [3:0] retry_inc(input logic [3:0] r);
        if (r >= RETRY_MAX) begin
            return RETRY_MAX;
        end
        return r + 4'd1;
    endfunction

    // Down-counter step that holds at zero once it gets there.
    function automatic logic [19:0] cnt_dec(input logic [19:0] c);
        if (c == 20'd0) begin
            return 20'd0;
        end
        return c - 20'd1;
    endfunction

    // Synchronizer next values: shift the raw inputs one stage per clock.
    always_comb begin
        lk_meta_d = bus.cplllock;
        lk_s_d    = lk_meta_q;
        rl_meta_d = bus.cpllrefclklost;
        rl_s_d    = rl_meta_q;
    end

    // Next-state, counter, retry and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_dec(cnt_q);
        retries_d = retries_q;
        cnt_last  = (cnt_q <= 20'd1);
        lock_lost = !lk_s_q || rl_s_q;

        case (state_q)
            S_IDLE: begin
                // Leaving IDLE is handled by the start override below.
                cnt_d = 20'd0;
            end
            S_PD: begin
                if (cnt_last) begin
                    state_d = S_RST;
                    cnt_d   = RST_LOAD;
                end
            end
            S_RST: begin
                if (cnt_last) begin
                    state_d = S_WAIT;
                    cnt_d   = LOCK_LOAD;
                end
            end
            S_WAIT: begin
                if (lk_s_q && !rl_s_q) begin
                    state_d = S_LOCKED;
                    cnt_d   = 20'd0;
                end else if (cnt_last || rl_s_q) begin
                    if (retries_q < RETRY_MAX) begin
                        retries_d = retry_inc(retries_q);
                        state_d   = S_RST;
                        cnt_d     = RST_LOAD;
                    end else begin
                        state_d = S_FAIL;
                        cnt_d   = 20'd0;
                    end
                end
            end
            S_LOCKED: begin
                cnt_d = 20'd0;
                if (lock_lost) begin
`ifdef GTXE2_CHNL_CPLL_SEQ_AUTORESTART_EN
                    retries_d = 4'd0;
                    state_d   = S_RST;
                    cnt_d     = RST_LOAD;
`else
                    state_d   = S_FAIL;
`endif
                end
            end
            S_FAIL: begin
                cnt_d = 20'd0;
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = 20'd0;
                retries_d = 4'd0;
            end
        endcase

        // A start request overrides every other transition.
        if (bus.start) begin
            state_d   = S_PD;
            cnt_d     = PD_LOAD;
            retries_d = 4'd0;
        end

        cpllpd_d     = (state_d == S_IDLE) || (state_d == S_PD) || (state_d == S_FAIL);
        cpllreset_d  = (state_d == S_RST);
        cplllocken_d = (state_d == S_WAIT) || (state_d == S_LOCKED);
        fail_d       = (state_d == S_FAIL);
        // done rises one cycle after LOCKED is entered and drops on the same
        // edge that leaves LOCKED.
        done_d       = (state_q == S_LOCKED) && (state_d == S_LOCKED);
    end

    // State, counter, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 20'd0;
            retries_q    <= 4'd0;
            lk_meta_q    <= 1'b0;
            lk_s_q       <= 1'b0;
            rl_meta_q    <= 1'b0;
            rl_s_q       <= 1'b0;
            cpllpd_q     <= 1'b1;
            cpllreset_q  <= 1'b0;
            cplllocken_q <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            lk_meta_q    <= lk_meta_d;
            lk_s_q       <= lk_s_d;
            rl_meta_q    <= rl_meta_d;
            rl_s_q       <= rl_s_d;
            cpllpd_q     <= cpllpd_d;
            cpllreset_q  <= cpllreset_d;
            cplllocken_q <= cplllocken_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign bus.cpllpd     = cpllpd_q;
    assign bus.cpllreset  = cpllreset_q;
    assign bus.cplllocken = cplllocken_q;
    assign bus.done       = done_q;
    assign bus.fail       = fail_q;
    assign bus.retries    = retries_q;

endmodule

// File: tb/tb_gtxe2_chnl_cpll_seq.sv
// Scoreboard bench for gtxe2_chnl_cpll_seq. Two instances run side by side:
// dut_a with default parameters, dut_b with LOCK_TIMEOUT=64, MAX_RETRIES=2.
// Stimulus pushes the expected output vector and the clock cycle of every
// output change. A monitor pops one entry per observed change and compares.
// Vector layout: {cpllpd, cpllreset, cplllocken, done, fail, retries[3:0]}.
module tb_gtxe2_chnl_cpll_seq;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gtxe2_chnl_cpll_seq_if if_a ();
    gtxe2_chnl_cpll_seq_if if_b ();

    gtxe2_chnl_cpll_seq dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (if_a)
    );

    gtxe2_chnl_cpll_seq #(
        .PD_CYCLES    (16),
        .RESET_CYCLES (8),
        .LOCK_TIMEOUT (64),
        .MAX_RETRIES  (2)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (if_b)
    );

    typedef struct {
        int         cyc;
        logic [8:0] vec;
        string      tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   end_req = 1'b0;

    function automatic logic [8:0] vec9(input logic pd, input logic rs, input logic le,
                                        input logic dn, input logic fl, input logic [3:0] rt);
        return {pd, rs, le, dn, fl, rt};
    endfunction

    function automatic void push_a(input int c, input logic [8:0] v, input string t);
        exp_t e;
        e.cyc = c; e.vec = v; e.tag = t;
        q_a.push_back(e);
    endfunction

    function automatic void push_b(input int c, input logic [8:0] v, input string t);
        exp_t e;
        e.cyc = c; e.vec = v; e.tag = t;
        q_b.push_back(e);
    endfunction

    // Advance to just after clock edge k.
    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_a(output int s);
        if_a.start = 1'b1;
        s = cyc + 1;
        wait_cyc(s);
        if_a.start = 1'b0;
    endtask

    task automatic pulse_b(output int s);
        if_b.start = 1'b1;
        s = cyc + 1;
        wait_cyc(s);
        if_b.start = 1'b0;
    endtask

    // dut_a: nominal lock, lock loss, reset in RST, start in WAIT, refclk loss.
    task automatic stim_a();
        int s, w, l, s2, s3, s4, w4;
        wait_cyc(3);
        reset_a = 1'b0;

        wait_cyc(5);
        pulse_a(s);
        push_a(s + 16, vec9(0, 1, 0, 0, 0, 0), "nominal_rst_entry");
        push_a(s + 24, vec9(0, 0, 1, 0, 0, 0), "nominal_wait_entry");
        w = s + 24;
        wait_cyc(w + 100);
        if_a.cplllock = 1'b1;
        push_a(w + 104, vec9(0, 0, 1, 1, 0, 0), "nominal_done");

        wait_cyc(w + 120);
        l = cyc;
        if_a.cplllock = 1'b0;
`ifdef GTXE2_CHNL_CPLL_SEQ_AUTORESTART_EN
        push_a(l + 3,  vec9(0, 1, 0, 0, 0, 0), "lockloss_restart_rst");
        push_a(l + 11, vec9(0, 0, 1, 0, 0, 0), "lockloss_restart_wait");
        push_a(l + 13, vec9(0, 0, 1, 1, 0, 0), "lockloss_relock_done");
`else
        push_a(l + 3,  vec9(1, 0, 0, 0, 1, 0), "lockloss_fail");
`endif
        wait_cyc(l + 3);
        if_a.cplllock = 1'b1;
        wait_cyc(l + 40);

        if_a.cplllock = 1'b0;
        pulse_a(s2);
        push_a(s2,      vec9(1, 0, 0, 0, 0, 0), "restart_pd");
        push_a(s2 + 16, vec9(0, 1, 0, 0, 0, 0), "restart_rst_entry");
        wait_cyc(s2 + 19);
        reset_a    = 1'b1;
        if_a.start = 1'b1;
        push_a(s2 + 20, vec9(1, 0, 0, 0, 0, 0), "reset_in_rst");
        wait_cyc(s2 + 20);
        reset_a    = 1'b0;
        if_a.start = 1'b0;

        wait_cyc(s2 + 25);
        pulse_a(s3);
        push_a(s3 + 16, vec9(0, 1, 0, 0, 0, 0), "post_reset_rst_entry");
        push_a(s3 + 24, vec9(0, 0, 1, 0, 0, 0), "post_reset_wait_entry");
        wait_cyc(s3 + 29);
        if_a.start = 1'b1;
        push_a(s3 + 30, vec9(1, 0, 0, 0, 0, 0), "start_in_wait_pd");
        wait_cyc(s3 + 30);
        if_a.start = 1'b0;

        s4 = s3 + 30;
        w4 = s4 + 24;
        push_a(s4 + 16, vec9(0, 1, 0, 0, 0, 0), "refclk_seq_rst_entry");
        push_a(w4,      vec9(0, 0, 1, 0, 0, 0), "refclk_seq_wait_entry");
        wait_cyc(w4 + 10);
        if_a.cpllrefclklost = 1'b1;
        push_a(w4 + 13, vec9(0, 1, 0, 0, 0, 1), "refclk_retry_rst");
        push_a(w4 + 21, vec9(0, 0, 1, 0, 0, 1), "refclk_retry_wait");
        wait_cyc(w4 + 15);
        if_a.cpllrefclklost = 1'b0;
        wait_cyc(w4 + 30);
        if_a.cplllock = 1'b1;
        push_a(w4 + 34, vec9(0, 0, 1, 1, 0, 1), "refclk_relock_done");
        wait_cyc(w4 + 50);
    endtask

    // dut_b: timeouts until retries run out, restart from FAIL, refclk loss while locked.
    task automatic stim_b();
        int sb, sf;
        wait_cyc(3);
        reset_b = 1'b0;

        wait_cyc(7);
        pulse_b(sb);
        push_b(sb + 16,  vec9(0, 1, 0, 0, 0, 0), "timeout_rst0");
        push_b(sb + 24,  vec9(0, 0, 1, 0, 0, 0), "timeout_wait0");
        push_b(sb + 88,  vec9(0, 1, 0, 0, 0, 1), "timeout_rst1");
        push_b(sb + 96,  vec9(0, 0, 1, 0, 0, 1), "timeout_wait1");
        push_b(sb + 160, vec9(0, 1, 0, 0, 0, 2), "timeout_rst2");
        push_b(sb + 168, vec9(0, 0, 1, 0, 0, 2), "timeout_wait2");
        push_b(sb + 232, vec9(1, 0, 0, 0, 1, 2), "timeout_fail");
        wait_cyc(sb + 250);

        pulse_b(sf);
        push_b(sf,      vec9(1, 0, 0, 0, 0, 0), "start_clears_fail");
        push_b(sf + 16, vec9(0, 1, 0, 0, 0, 0), "second_rst_entry");
        push_b(sf + 24, vec9(0, 0, 1, 0, 0, 0), "second_wait_entry");
        wait_cyc(sf + 30);
        if_b.cplllock = 1'b1;
        push_b(sf + 34, vec9(0, 0, 1, 1, 0, 0), "second_done");
        wait_cyc(sf + 40);
        if_b.cpllrefclklost = 1'b1;
`ifdef GTXE2_CHNL_CPLL_SEQ_AUTORESTART_EN
        push_b(sf + 43, vec9(0, 1, 0, 0, 0, 0), "locked_refclk_restart");
        push_b(sf + 51, vec9(0, 0, 1, 0, 0, 0), "locked_refclk_wait");
        push_b(sf + 53, vec9(0, 0, 1, 1, 0, 0), "locked_refclk_relock");
`else
        push_b(sf + 43, vec9(1, 0, 0, 0, 1, 0), "locked_refclk_fail");
`endif
        wait_cyc(sf + 41);
        if_b.cpllrefclklost = 1'b0;
        wait_cyc(sf + 70);
    endtask

    task automatic check_one(input string who, input logic [8:0] got, input exp_t e);
        checks++;
        if (got !== e.vec || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s %s: got %b at cycle %0d, required %b at cycle %0d",
                     who, e.tag, got, cyc, e.vec, e.cyc);
        end
    endtask

    // Monitor: compare every output change against the scoreboard queues.
    initial begin
        logic [8:0] va, vb, prev_a, prev_b;
        exp_t e;
        prev_a = 'x;
        prev_b = 'x;
        forever begin
            @(negedge clk);
            va = {if_a.cpllpd, if_a.cpllreset, if_a.cplllocken, if_a.done, if_a.fail, if_a.retries};
            vb = {if_b.cpllpd, if_b.cpllreset, if_b.cplllocken, if_b.done, if_b.fail, if_b.retries};
            if (va !== prev_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut_a unexpected_change: got %b at cycle %0d, required no change from %b",
                             va, cyc, prev_a);
                end else begin
                    e = q_a.pop_front();
                    check_one("dut_a", va, e);
                end
                prev_a = va;
            end
            if (vb !== prev_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut_b unexpected_change: got %b at cycle %0d, required no change from %b",
                             vb, cyc, prev_b);
                end else begin
                    e = q_b.pop_front();
                    check_one("dut_b", vb, e);
                end
                prev_b = vb;
            end
            if (end_req) begin
                while (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL dut_a %s: got no change, required %b at cycle %0d", e.tag, e.vec, e.cyc);
                end
                while (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL dut_b %s: got no change, required %b at cycle %0d", e.tag, e.vec, e.cyc);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    // Stimulus driver.
    initial begin
        reset_a             = 1'b1;
        reset_b             = 1'b1;
        if_a.start          = 1'b0;
        if_a.cplllock       = 1'b0;
        if_a.cpllrefclklost = 1'b0;
        if_b.start          = 1'b0;
        if_b.cplllock       = 1'b0;
        if_b.cpllrefclklost = 1'b0;
        push_a(1, vec9(1, 0, 0, 0, 0, 0), "reset_values");
        push_b(1, vec9(1, 0, 0, 0, 0, 0), "reset_values");
        fork
            stim_a();
            stim_b();
        join
        wait_cyc(cyc + 5);
        end_req = 1'b1;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gtxe2_chnl_cpll_seq.md
GTXE2_CHNL_CPLL_SEQ -- requirements
Module: gtxe2_chnl_cpll_seq

Interface
REQ-001 SHALL have parameter PD_CYCLES, default 16: cycles CPLLPD is held high after start; legal range 1..65535.
REQ-002 SHALL have parameter RESET_CYCLES, default 8: cycles CPLLRESET is held high after power-down release; legal range 1..65535.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed for lock before a retry; legal range 1..2^20-1.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: lock attempts after the first before failing; legal range 0..15.
REQ-005 clk  input  1  sequencer clock; the same clock drives CPLLLOCKDETCLK.
REQ-006 reset  input  1  reset; synchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin or restart the power-up sequence.
REQ-008 cplllock  input  1  CPLLLOCK from the channel PLL; asynchronous, synchronized inside the block.
REQ-009 cpllrefclklost  input  1  CPLLREFCLKLOST; asynchronous, synchronized inside the block.
REQ-010 cpllpd  output  1  drives CPLLPD.
REQ-011 cpllreset  output  1  drives CPLLRESET.
REQ-012 cplllocken  output  1  drives CPLLLOCKEN.
REQ-013 done  output  1  PLL locked and stable.
REQ-014 fail  output  1  retries exhausted; sticky until start or reset.
REQ-015 retries  output  4  number of retries used in the current sequence.

Function
REQ-016 SHALL pass cplllock and cpllrefclklost through 2-flop synchronizers (lk_s, rl_s) before any use.
REQ-017 SHALL implement the states IDLE, PD, RST, WAIT, LOCKED, FAIL, sharing one down-counter of 20 bits.
REQ-018 IDLE: cpllpd=1, cpllreset=0. On start, go to PD and load PD_CYCLES.
REQ-019 PD: cpllpd=1. When the counter reaches 0, go to RST and load RESET_CYCLES.
REQ-020 RST: cpllpd=0, cpllreset=1. When the counter reaches 0, go to WAIT and load LOCK_TIMEOUT.
REQ-021 WAIT: cpllpd=0, cpllreset=0, cplllocken=1.
  - If lk_s=1 and rl_s=0, go to LOCKED.
  - If the counter reaches 0 or rl_s=1, and retries<MAX_RETRIES: increment retries, go to RST, load RESET_CYCLES.
  - Otherwise, in the same condition, go to FAIL.
REQ-022 LOCKED: done=1 and cplllocken=1; done is registered and asserts the cycle after the state is entered.
REQ-023 LOCKED: if lk_s falls or rl_s rises, done SHALL deassert on the next clock.
REQ-024 FAIL: fail=1, cpllpd=1, done=0.
REQ-025 start in any state other than IDLE SHALL clear retries and fail and re-enter PD; start wins over every other transition in the same cycle.
REQ-026 The counter SHALL be loaded on state entry and decrement once per cycle; a state with a load value N lasts exactly N cycles.
REQ-027 retries SHALL saturate at MAX_RETRIES and never wrap.
REQ-028 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-029 On reset=1 at a clk edge, the block SHALL enter IDLE.
REQ-030 Reset values: cpllpd=1, cpllreset=0, cplllocken=0, done=0, fail=0, retries=0, counter=0, synchronizers=0.
REQ-031 Reset mid-sequence SHALL abort immediately and ignore a start in the same cycle.

Configuration
REQ-032 Macro GTXE2_CHNL_CPLL_SEQ_AUTORESTART_EN.
  - Defined: lock loss in LOCKED (REQ-023) clears retries and moves to RST with RESET_CYCLES loaded; an automatic re-lock follows.
  - Undefined: lock loss in LOCKED moves to FAIL; fail=1 until start or reset.

Verification
REQ-033 Defaults; start at cycle 0; cplllock rises 100 cycles after cpllreset falls -> cpllpd high for 16 cycles, cpllreset high for 8 cycles, done=1 at about 103 cycles after WAIT entry, retries=0.
REQ-034 LOCK_TIMEOUT=64, MAX_RETRIES=2, cplllock held 0 -> three WAIT windows of 64 cycles each, then fail=1, retries=2, cpllpd=1.
REQ-035 cpllrefclklost pulsed for 5 cycles mid-WAIT -> retry starts within 3 cycles of the pulse, retries=1, then lock completes normally.
REQ-036 Locked, then cplllock dropped -> done=0 within 3 cycles; with the macro, the sequence re-enters RST; without it, fail=1.
REQ-037 reset asserted in RST and start asserted in WAIT -> reset: IDLE with all outputs at reset values next cycle; start: PD entered next cycle, retries=0.
